// File: rtl/comm_pkg.sv
// Shared constants for the command receive path: message types, response
// codes, legal message lengths, parser state encoding and the job record.
package comm_pkg;

  localparam logic [7:0] TYPE_GET_INFO = 8'h00;
  localparam logic [7:0] TYPE_PUSH_JOB = 8'h02;

  localparam logic [1:0] RESP_PONG    = 2'd0;
  localparam logic [1:0] RESP_INFO    = 2'd1;
  localparam logic [1:0] RESP_INVALID = 2'd2;
  localparam logic [1:0] RESP_ACK     = 2'd3;

  localparam logic [5:0] INFO_LEN = 6'd8;
  localparam logic [5:0] JOB_LEN  = 6'd60;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HDR     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_DISCARD = 2'd3;

  typedef struct packed {
    logic [255:0] midstate;
    logic [95:0]  data;
    logic [31:0]  noncemin;
    logic [31:0]  noncemax;
  } job_t;

  // A nonzero LEN that can never frame a message: shorter than the header,
  // not word aligned, or longer than the largest message.
  function automatic logic len_bad(input logic [7:0] len);
    return (len < 8'd4) || (len[1:0] != 2'b00) || (len > 8'd60);
  endfunction

endpackage

// File: rtl/comm_rx_parser_if.sv
// Byte input, response handshake and job outputs of the receive parser.
// slave = parser side, master = UART/framer/consumer side.
interface comm_rx_parser_if;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         resp_valid;
  logic [1:0]   resp_type;
  logic         resp_ready;
  logic         new_work;
  logic [255:0] midstate;
  logic [95:0]  data;
  logic [31:0]  noncemin;
  logic [31:0]  noncemax;
  logic         err_overrun;

  modport slave (
    input  rx_data, rx_valid, resp_ready,
    output resp_valid, resp_type, new_work, midstate, data, noncemin, noncemax, err_overrun
  );

  modport master (
    output rx_data, rx_valid, resp_ready,
    input  resp_valid, resp_type, new_work, midstate, data, noncemin, noncemax, err_overrun
  );
endinterface

// File: rtl/comm_timeout.sv
// Inter-byte watchdog: restarted by every byte of an open message, disarmed
// when the parser returns to idle, strobes o_expire in the last allowed cycle.
module comm_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_clear,
  output logic o_expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_cnt;
  logic         r_active;

  // Count idle cycles since the most recent byte while a message is open.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (i_clear) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (r_active) begin
      r_cnt    <= r_cnt + W'(1);
    end else begin
      r_cnt    <= r_cnt;
    end
  end

  // The parser gives a byte in this cycle priority over the strobe.
  assign o_expire = r_active && (r_cnt == LIMIT);

endmodule

// File: rtl/comm_rx_parser.sv
// Command parser: frames LEN-prefixed messages from the UART byte stream,
// requests responses from the TX framer and publishes mining jobs atomically.
module comm_rx_parser
  import comm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic CLK,
  input logic RST_N,
  comm_rx_parser_if.slave bus
);

  logic [1:0]   r_state, w_state_nxt;
  logic [5:0]   r_cnt, w_cnt_nxt;
  logic [5:0]   r_len, w_len_nxt;
  logic         r_is_job, w_is_job_nxt;
  logic         w_resp_req;
  logic [1:0]   w_resp_code;
  logic         w_commit;
  logic         w_expire;
  logic         w_last;
  logic [5:0]   w_pidx;
  logic [447:0] r_shadow, w_shadow;
  job_t         r_job;
  logic         r_resp_valid;
  logic [1:0]   r_resp_type;
  logic         r_new_work;
  logic         r_overrun;

  assign w_last = ((r_cnt + 6'd1) == r_len);
  assign w_pidx = r_cnt - 6'd4;

  comm_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .i_clk    (CLK),
    .i_rst_n  (RST_N),
    .i_load   (bus.rx_valid && (w_state_nxt != ST_IDLE)),
    .i_clear  (w_state_nxt == ST_IDLE),
    .o_expire (w_expire)
  );

  // Message framing: next state, byte count, response request and job commit.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_len_nxt    = r_len;
    w_is_job_nxt = r_is_job;
    w_resp_req   = 1'b0;
    w_resp_code  = RESP_PONG;
    w_commit     = 1'b0;
    w_shadow     = r_shadow;
    w_shadow[{w_pidx, 3'b000} +: 8] = bus.rx_data;
    case (r_state)
      ST_IDLE: begin
        if (!bus.rx_valid) begin
          w_cnt_nxt = 6'd0;
        end else if (bus.rx_data == 8'h00) begin
          w_resp_req  = 1'b1;
          w_resp_code = RESP_PONG;
        end else if (len_bad(bus.rx_data)) begin
          w_resp_req  = 1'b1;
          w_resp_code = RESP_INVALID;
        end else begin
          w_len_nxt   = bus.rx_data[5:0];
          w_cnt_nxt   = 6'd1;
          w_state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        if (bus.rx_valid) begin
          w_cnt_nxt = r_cnt + 6'd1;
          if (r_cnt != 6'd3) begin
            // LEN >= 4, so a reserved byte can never be the last one.
            w_state_nxt = (bus.rx_data != 8'h00) ? ST_DISCARD : ST_HDR;
          end else if ((bus.rx_data == TYPE_GET_INFO) && (r_len == INFO_LEN)) begin
            w_state_nxt  = ST_PAYLOAD;
            w_is_job_nxt = 1'b0;
          end else if ((bus.rx_data == TYPE_PUSH_JOB) && (r_len == JOB_LEN)) begin
            w_state_nxt  = ST_PAYLOAD;
            w_is_job_nxt = 1'b1;
          end else if (w_last) begin
            w_resp_req  = 1'b1;
            w_resp_code = RESP_INVALID;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 6'd0;
          end else begin
            w_state_nxt = ST_DISCARD;
          end
        end else if (w_expire) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 6'd0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_PAYLOAD: begin
        if (bus.rx_valid) begin
          w_cnt_nxt = r_cnt + 6'd1;
          if (w_last) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 6'd0;
            w_resp_req  = 1'b1;
            w_resp_code = r_is_job ? RESP_ACK : RESP_INFO;
            w_commit    = r_is_job;
          end else begin
            w_state_nxt = ST_PAYLOAD;
          end
        end else if (w_expire) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 6'd0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_DISCARD: begin
        if (bus.rx_valid) begin
          w_cnt_nxt = r_cnt + 6'd1;
          if (w_last) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 6'd0;
            w_resp_req  = 1'b1;
            w_resp_code = RESP_INVALID;
          end else begin
            w_state_nxt = ST_DISCARD;
          end
        end else if (w_expire) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 6'd0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 6'd0;
      end
    endcase
  end

  // Parser state, byte counter and shadow payload collection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 6'd0;
      r_len    <= 6'd0;
      r_is_job <= 1'b0;
      r_shadow <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_len    <= w_len_nxt;
      r_is_job <= w_is_job_nxt;
      if ((r_state == ST_PAYLOAD) && bus.rx_valid) begin
        r_shadow <= w_shadow;
      end else begin
        r_shadow <= r_shadow;
      end
    end
  end

  // Job outputs change only when a complete PUSH_JOB commits, all fields at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_job      <= '0;
      r_new_work <= 1'b0;
    end else begin
      r_new_work <= w_commit;
      if (w_commit) begin
        r_job.noncemax <= w_shadow[63:32];
        r_job.noncemin <= w_shadow[95:64];
        r_job.data     <= w_shadow[191:96];
        r_job.midstate <= w_shadow[447:192];
      end else begin
        r_job <= r_job;
      end
    end
  end

  // Response holding register; a request arriving while one is stalled is dropped.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_resp_valid <= 1'b0;
      r_resp_type  <= 2'd0;
      r_overrun    <= 1'b0;
    end else if (w_resp_req && r_resp_valid && !bus.resp_ready) begin
      r_overrun    <= 1'b1;
    end else if (w_resp_req) begin
      r_resp_valid <= 1'b1;
      r_resp_type  <= w_resp_code;
      r_overrun    <= 1'b0;
    end else if (r_resp_valid && bus.resp_ready) begin
      r_resp_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun    <= 1'b0;
    end
  end

  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_type   = r_resp_type;
  assign bus.err_overrun = r_overrun;
  assign bus.new_work    = r_new_work;
  assign bus.midstate    = r_job.midstate;
  assign bus.data        = r_job.data;
  assign bus.noncemin    = r_job.noncemin;
  assign bus.noncemax    = r_job.noncemax;

endmodule

// File: doc/comm_rx_parser.md
COMM_RX_PARSER -- requirements
Module: comm_rx_parser

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000: maximum allowed CLK cycles between two bytes of one message.
REQ-002 CLK  input  1  system clock; every register updates on its rising edge.
REQ-003 RST_N  input  1  reset, asynchronous and active-low.
REQ-004 rx_data  input  8  received byte from the UART receiver.
REQ-005 rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-006 resp_valid  output  1  response request to the TX framer.
REQ-007 resp_type  output  2  response code: 0 PONG, 1 INFO, 2 INVALID, 3 ACK.
REQ-008 resp_ready  input  1  framer accepts the response when resp_valid && resp_ready.
REQ-009 new_work  output  1  one-cycle pulse; a new job is present on the job outputs.
REQ-010 midstate  output  256  job midstate.
REQ-011 data  output  96  job header tail (time, merkle, bits).
REQ-012 noncemin, noncemax  output  32 each  job nonce range.
REQ-013 err_overrun  output  1  one-cycle pulse; a response was dropped.

Function
REQ-014 Message format: byte0 = LEN; bytes1-2 must be 0x00; byte3 = TYPE; the payload follows; LEN counts every byte including byte0.
REQ-015 If LEN == 0x00, the parser shall request PONG and return to IDLE.
REQ-016 If LEN is 1..3, not a multiple of 4, or greater than 60, the parser shall request INVALID immediately and return to IDLE.
REQ-017 States: IDLE, HDR (bytes 1-3), PAYLOAD, DISCARD; the byte counter is 6 bits and counts accepted bytes.
REQ-018 A nonzero byte1 or byte2, or a TYPE other than 0x00 or 0x02, shall move the parser to DISCARD; when LEN bytes have been consumed it shall request INVALID.
REQ-019 TYPE 0x00 (GET_INFO) requires LEN == 8; payload bytes are ignored; completion shall request INFO, and any other LEN shall request INVALID.
REQ-020 TYPE 0x02 (PUSH_JOB) requires LEN == 60; any other LEN shall request INVALID.
REQ-021 PUSH_JOB payload is 14 words w0..w13; each word is received LSB first.
REQ-022 PUSH_JOB mapping: w0 ignored; w1 = noncemax; w2 = noncemin; data = {w5,w4,w3}; midstate = {w13,...,w6}.
REQ-023 Payload shall be collected in a shadow register; the job outputs shall update atomically only on successful completion.
REQ-024 PUSH_JOB completion timing: the cycle after the last byte's rx_valid, new_work shall pulse for exactly one cycle, the outputs shall hold the new job, and ACK shall be requested.
REQ-025 Latency: every response request shall appear exactly one cycle after the rx_valid that decides it.
REQ-026 Handshake: resp_valid and resp_type shall stay stable until resp_ready; resp_valid shall fall the cycle after acceptance.
REQ-027 If a new response arises while resp_valid && !resp_ready, the new one shall be dropped and err_overrun shall pulse; parsing shall continue.
REQ-028 A new response arising in the same cycle as acceptance shall be loaded, not dropped.
REQ-029 Timeout: in HDR, PAYLOAD or DISCARD, TIMEOUT_CYCLES cycles with no rx_valid shall return the parser to IDLE with no response and the job outputs unchanged.
REQ-030 Job outputs shall hold their last value indefinitely; an invalid or timed-out message shall never alter them.

Reset
REQ-031 While RST_N is low: state = IDLE, counters = 0, resp_valid = 0, resp_type = 0, new_work = 0, err_overrun = 0, midstate/data/noncemin/noncemax = 0.
REQ-032 Reset asserted mid-message shall discard the partial message; after release the next byte shall be treated as LEN.

Structure
REQ-033 A shared package comm_pkg shall hold the message type codes (GET_INFO 0, PUSH_JOB 2), the response codes (REQ-007), the lengths (INFO_LEN 8, JOB_LEN 60) and the state encoding.
REQ-034 The inter-byte timeout counter shall be the sub-module comm_timeout (load/clear, expiry strobe); everything else stays flat.

Verification
REQ-035 Byte 0x00 -> resp_type PONG one cycle later, held until resp_ready.
REQ-036 08 00 00 00 f9 ea 98 0a -> INFO; the job outputs are unchanged.
REQ-037 Single byte 0x06 -> INVALID one cycle later; the next byte 0x00 -> PONG.
REQ-038 Genesis PUSH_JOB: LEN 3C 00 00 02, then words 00000000, FFFFFFFF, 1DAC2B7B, 4B1E5E4A, 29AB5F49, FFFF001D, BC909A33 ... 4719F91B, each sent LSB first -> new_work pulse, noncemin 1DAC2B7B, noncemax FFFFFFFF, data FFFF001D29AB5F494B1E5E4A, midstate 4719F91B...BC909A33, ACK.
REQ-039 PUSH_JOB stopped after 20 bytes, then TIMEOUT_CYCLES idle cycles, then PING -> PONG only, no new_work, job unchanged.
REQ-040 resp_ready held low, then PING, then PING -> first PONG held, err_overrun pulses once; RST_N pulsed mid-PUSH_JOB -> all outputs 0.
